fft16_input_commutator: RTL and testbench
=========================================

Name: fft16_input_commutator

Overview:
- Serial-to-parallel front end of the 16-point radix-4 FFT pipeline.
- Accepts one complex sample per accepted beat in natural order (x[0]..x[15]).
- Emits 4 parallel lanes over 4 consecutive beats, each tagged with a 2-bit phase. At phase p the lanes carry x[p], x[p+4], x[p+8], x[p+12], which is the operand set of the first radix-4 DIF butterfly.
- It produces the lane/phase stream that the stage-1 butterfly and the stage-2 commutator consume.

Parameters:
- DATA_W, 32: sample width; packed complex {re[DATA_W/2-1:0], im}, treated as opaque data.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  data_in is accepted this cycle
- frame_start  input  1  marks data_in as x[0] and forces resynchronisation
- data_in  input  DATA_W  signed serial sample
- output_0  output  DATA_W  lane 0 = x[p]
- output_1  output  DATA_W  lane 1 = x[p+4]
- output_2  output  DATA_W  lane 2 = x[p+8]
- output_3  output  DATA_W  lane 3 = x[p+12]
- mux_1_out  output  2  phase tag p of the current lane set
- out_valid  output  1  lanes and mux_1_out are valid this cycle
- out_last  output  1  asserted with the p=3 lane set (frame complete)
- sync_err  output  1  one-cycle pulse: frame_start arrived mid-frame

Behaviour:
- Reset (reset=0, async): idx=0, buf[0..11]=0, all outputs=0, out_valid=0, out_last=0, sync_err=0, mux_1_out=2'b00.
- idx is a 4-bit sample index. Storage is buf[0..11] of DATA_W registers. x[12..15] are never stored; they bypass directly to lane 3.
- Accepted beat means in_valid=1. The effective index is e = 0 if frame_start=1, otherwise e = idx. On each accepted beat idx <= e+1, wrapping 15->0.
- Accepted beat with e<12: buf[e] <= data_in; out_valid <= 0.
- Accepted beat with e>=12, p = e-12; all of the following are registered:
  - output_0 <= buf[p], output_1 <= buf[p+4], output_2 <= buf[p+8], output_3 <= data_in.
  - mux_1_out <= p; out_valid <= 1; out_last <= (p==3).
- Latency: one cycle from acceptance of x[12+p] to its lane set at the outputs.
- Non-accepted cycle: out_valid <= 0 and out_last <= 0. Lanes and mux_1_out hold their values. idx and buf are unchanged, so gaps in in_valid are tolerated at any point.
- Streaming: x'[0..3] of the next frame overwrite buf[0..3] only after the phase-3 read, so back-to-back frames need no stall. Sustained throughput is 16 samples per 16 beats.
- frame_start with in_valid=1 and idx!=0: sync_err <= 1 for one cycle. The partial frame is discarded, no lane sets are emitted for it, and the current sample becomes x[0].
- frame_start with in_valid=0: ignored. There is no effect on idx and no sync_err.
- frame_start with idx==0: normal; no sync_err.
- Reset asserted mid-frame: immediate clear. The next accepted sample is x[0], with or without frame_start.
- No arithmetic is performed; data is passed bit-exact.

Test Plan:
- Single frame: reset, then 16 consecutive beats with data_in=k+1 (k=0..15) and frame_start on the first beat. Required response:
  - out_valid high for exactly 4 cycles, starting the cycle after beat 12.
  - (mux_1_out, lanes) = (0: 1,5,9,13), (1: 2,6,10,14), (2: 3,7,11,15), (3: 4,8,12,16).
  - out_last high only on phase 3.
- Back-to-back: 3 frames of 48 continuous beats with data_in=frame*100+k. Required response: 12 lane sets in order, each matching its frame's pattern; no stall; out_valid high in the pattern 12 low, 4 high, repeated.
- Gappy input: in_valid toggled 1,0,1,0 across one frame. Required response: same 4 lane sets as the single-frame test; out_valid low on idle cycles; lanes held between sets.
- Resync: frame_start at beat 7 of a frame. Required response:
  - sync_err=1 for one cycle.
  - No lane sets for the aborted frame.
  - The following 16 samples produce the correct 4 lane sets.
- Reset mid-frame: assert reset=0 after 13 samples (phase 0 already emitted). Required response: all outputs 0 immediately; the next 16 samples yield a correct frame starting at mux_1_out=0.
- Wrap without frame_start: 2 frames with frame_start only on the first beat. Required response: the second frame aligns correctly through idx wrap 15->0; sync_err stays 0.

Source files
------------

// File: rtl/fft16_input_commutator_if.sv
`default_nettype none
// ============================================================================
// Module   : fft16_input_commutator_if
// Brief    : Sample-in / lane-set-out bundle of the 16-point radix-4 FFT
//            input commutator. The master is the sample source and lane-set
//            consumer; the slave is the commutator itself.
// Revision : 1.0 - initial release
// ============================================================================
interface fft16_input_commutator_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              frame_start;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] output_0;
  logic [DATA_W-1:0] output_1;
  logic [DATA_W-1:0] output_2;
  logic [DATA_W-1:0] output_3;
  logic [1:0]        mux_1_out;
  logic              out_valid;
  logic              out_last;
  logic              sync_err;

  modport master (
    output in_valid, frame_start, data_in,
    input  output_0, output_1, output_2, output_3,
    input  mux_1_out, out_valid, out_last, sync_err
  );

  modport slave (
    input  in_valid, frame_start, data_in,
    output output_0, output_1, output_2, output_3,
    output mux_1_out, out_valid, out_last, sync_err
  );
endinterface
`default_nettype wire

// File: rtl/fft16_input_commutator.sv
`default_nettype none
// ============================================================================
// Module   : fft16_input_commutator
// Brief    : Serial-to-parallel front end of the 16-point radix-4 FFT.
//            Stores x[0..11] of a natural-order frame and, as each of
//            x[12..15] arrives, emits the lane set {x[p], x[p+4], x[p+8],
//            x[p+12]} tagged with phase p, one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module fft16_input_commutator #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  fft16_input_commutator_if.slave  bus
);

  localparam int         c_DEPTH      = 12;
  localparam logic [3:0] c_TAIL_START = 4'd12;

  // Frame position and sample storage. x[12..15] are never stored: they
  // go straight to lane 3 in the cycle they arrive.
  logic [3:0]        r_idx;
  logic [DATA_W-1:0] r_buf [0:c_DEPTH-1];

  // Registered outputs
  logic [DATA_W-1:0] r_out_0;
  logic [DATA_W-1:0] r_out_1;
  logic [DATA_W-1:0] r_out_2;
  logic [DATA_W-1:0] r_out_3;
  logic [1:0]        r_phase;
  logic              r_valid;
  logic              r_last;
  logic              r_sync_err;

  // Beat decode. frame_start forces the current sample to be x[0], so the
  // effective index ignores whatever position the counter had reached.
  logic              w_accept;
  logic [3:0]        w_eff;
  logic              w_tail;
  logic [1:0]        w_phase;
  logic [3:0]        w_rd_0;
  logic [3:0]        w_rd_1;
  logic [3:0]        w_rd_2;
  logic              w_resync;

  assign w_accept = bus.in_valid;
  assign w_eff    = bus.frame_start ? 4'd0 : r_idx;
  assign w_tail   = (w_eff >= c_TAIL_START);
  assign w_phase  = w_eff[1:0];
  // p, p+4 and p+8 are just p with the upper two bits set to 0, 1, 2.
  assign w_rd_0   = {2'b00, w_phase};
  assign w_rd_1   = {2'b01, w_phase};
  assign w_rd_2   = {2'b10, w_phase};
  // A resynchronisation only counts as an error if a frame was in progress.
  assign w_resync = w_accept && bus.frame_start && (r_idx != 4'd0);

  // Sample index: advances on every accepted beat and wraps 15 -> 0 so that
  // back-to-back frames need no frame_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx <= 4'd0;
    end else if (w_accept) begin
      r_idx <= w_eff + 4'd1;
    end
  end

  // Capture x[0..11]. The next frame's x'[0..3] only land here after the
  // phase-3 read of the current frame, so streaming frames never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept && !w_tail) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        if (w_eff == 4'(i)) begin
          r_buf[i] <= bus.data_in;
        end
      end
    end
  end

  // Lane set generation on x[12..15]; lanes and phase hold between sets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_0 <= '0;
      r_out_1 <= '0;
      r_out_2 <= '0;
      r_out_3 <= '0;
      r_phase <= 2'b00;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept && w_tail) begin
      r_out_0 <= r_buf[w_rd_0];
      r_out_1 <= r_buf[w_rd_1];
      r_out_2 <= r_buf[w_rd_2];
      r_out_3 <= bus.data_in;
      r_phase <= w_phase;
      r_valid <= 1'b1;
      r_last  <= (w_phase == 2'd3);
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  // One-cycle pulse when frame_start aborts a partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_resync;
    end
  end

  assign bus.output_0  = r_out_0;
  assign bus.output_1  = r_out_1;
  assign bus.output_2  = r_out_2;
  assign bus.output_3  = r_out_3;
  assign bus.mux_1_out = r_phase;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.sync_err  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_fft16_input_commutator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft16_input_commutator
// Brief    : Self-checking bench for fft16_input_commutator. A frame-level
//            model (samples collected per frame, lane sets taken from the
//            collected frame) predicts every output after every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft16_input_commutator;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft16_input_commutator_if #(.DATA_W(DATA_W)) bus ();

  fft16_input_commutator #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Frame-level reference: the samples of the frame in progress.
  logic [DATA_W-1:0] frame_q [$];
  logic [DATA_W-1:0] exp_lane [4];
  logic [1:0]        exp_phase;
  logic              exp_valid;
  logic              exp_last;
  logic              exp_sync;
  int                valid_seen = 0;
  int                sync_seen  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    for (int i = 0; i < 4; i++) exp_lane[i] = '0;
    exp_phase = 2'b00;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    exp_sync  = 1'b0;
  endtask

  // One clock of expected behaviour given the inputs presented at that edge.
  task automatic model_beat(input logic v, input logic fs, input logic [DATA_W-1:0] d);
    int n;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    exp_sync  = 1'b0;
    if (v) begin
      if (fs) begin
        exp_sync = (frame_q.size() != 0);
        frame_q.delete();
      end
      frame_q.push_back(d);
      n = frame_q.size();
      if (n > 12) begin
        exp_phase   = 2'(n - 13);
        exp_lane[0] = frame_q[n - 13];
        exp_lane[1] = frame_q[n - 9];
        exp_lane[2] = frame_q[n - 5];
        exp_lane[3] = frame_q[n - 1];
        exp_valid   = 1'b1;
        exp_last    = (n == 16);
      end
      if (n == 16) frame_q.delete();
    end
  endtask

  task automatic check_all();
    check("output_0",  64'(bus.output_0),  64'(exp_lane[0]));
    check("output_1",  64'(bus.output_1),  64'(exp_lane[1]));
    check("output_2",  64'(bus.output_2),  64'(exp_lane[2]));
    check("output_3",  64'(bus.output_3),  64'(exp_lane[3]));
    check("mux_1_out", 64'(bus.mux_1_out), 64'(exp_phase));
    check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    check("out_last",  64'(bus.out_last),  64'(exp_last));
    check("sync_err",  64'(bus.sync_err),  64'(exp_sync));
    if (bus.out_valid === 1'b1) valid_seen++;
    if (bus.sync_err === 1'b1)  sync_seen++;
  endtask

  task automatic step(input logic v, input logic fs, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.in_valid    = v;
    bus.frame_start = fs;
    bus.data_in     = d;
    @(posedge clk);
    model_beat(v, fs, d);
    #1;
    check_all();
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  int v0;
  int s0;

  initial begin
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    bus.data_in     = '0;
    model_reset();

    // Reset state
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Single frame, data k+1
    v0 = valid_seen;
    for (int k = 0; k < 16; k++) step(1'b1, k == 0, DATA_W'(k + 1));
    check("single_lane0", 64'(bus.output_0), 64'd4);
    check("single_lane1", 64'(bus.output_1), 64'd8);
    check("single_lane2", 64'(bus.output_2), 64'd12);
    check("single_lane3", 64'(bus.output_3), 64'd16);
    step(1'b0, 1'b0, '0);
    check("single_valid_count", 64'(valid_seen - v0), 64'd4);

    // Back-to-back: 3 frames, frame_start on every frame boundary
    v0 = valid_seen;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 16; k++) step(1'b1, k == 0, DATA_W'(f * 100 + k));
    check("b2b_valid_count", 64'(valid_seen - v0), 64'd12);

    // Gappy: accepted beats alternate with idle ones; frame_start on idle
    // beats must be ignored
    s0 = sync_seen;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0, DATA_W'(k + 1));
      step(1'b0, 1'($urandom_range(0, 1)), DATA_W'($urandom));
    end
    check("gappy_no_sync", 64'(sync_seen - s0), 64'd0);

    // Resync: abort at beat 7, then a full random frame
    s0 = sync_seen;
    v0 = valid_seen;
    for (int k = 0; k < 7; k++) step(1'b1, k == 0, DATA_W'($urandom));
    for (int k = 0; k < 16; k++) step(1'b1, k == 0, DATA_W'($urandom));
    check("resync_sync_count", 64'(sync_seen - s0), 64'd1);
    check("resync_valid_count", 64'(valid_seen - v0), 64'd4);

    // Reset mid-frame after 13 samples, then a frame without frame_start
    for (int k = 0; k < 13; k++) step(1'b1, k == 0, DATA_W'($urandom));
    async_reset();
    v0 = valid_seen;
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, DATA_W'($urandom));
    check("post_reset_valid_count", 64'(valid_seen - v0), 64'd4);

    // Wrap: two frames, frame_start only on the very first beat
    s0 = sync_seen;
    for (int k = 0; k < 32; k++) step(1'b1, k == 0, DATA_W'($urandom));
    check("wrap_no_sync", 64'(sync_seen - s0), 64'd0);

    // Random traffic: random gaps and occasional frame_start
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 19) == 0, DATA_W'($urandom));

    step(1'b0, 1'b0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
